// File: rtl/fast_pkg.sv
// Shared definitions for the FAST-16 segment test slice.
//   CIRCLE_N       : number of pixels on the Bresenham circle
//   DEF_DATA_WIDTH : default pixel width
//   score_width()  : width of a corner score for a given pixel width
//   pixel_t        : default-width pixel
//   circle_mask_t  : one bit per circle pixel, ring order
package fast_pkg;

  localparam int unsigned CIRCLE_N       = 16;
  localparam int unsigned DEF_DATA_WIDTH = 8;

  typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;
  typedef logic [CIRCLE_N-1:0]       circle_mask_t;

  // Sixteen DATA_WIDTH-bit diffs summed never exceed dw + 4 bits.
  function automatic int unsigned score_width(input int unsigned dw);
    return dw + 4;
  endfunction

endpackage

// File: rtl/fast_segment_test_if.sv
// Window-in / result-out bundle of the FAST segment test.
//   master : produces circle_valid, center_pixel, circle_pixel[0:15], threshold,
//            window_sof, window_eol; consumes the corner_* results
//   slave  : the segment test itself (mirror directions)
interface fast_segment_test_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned COORD_W    = 11
);
  import fast_pkg::*;

  localparam int unsigned SCORE_W = score_width(DATA_WIDTH);

  logic                  circle_valid;
  logic [DATA_WIDTH-1:0] center_pixel;
  logic [DATA_WIDTH-1:0] circle_pixel [0:CIRCLE_N-1];
  logic [DATA_WIDTH-1:0] threshold;
  logic                  window_sof;
  logic                  window_eol;

  logic                  corner_valid;
  logic                  is_corner;
  logic [SCORE_W-1:0]    corner_score;
  logic [COORD_W-1:0]    corner_x;
  logic [COORD_W-1:0]    corner_y;

  modport master (
    output circle_valid, center_pixel, circle_pixel, threshold, window_sof, window_eol,
    input  corner_valid, is_corner, corner_score, corner_x, corner_y
  );

  modport slave (
    input  circle_valid, center_pixel, circle_pixel, threshold, window_sof, window_eol,
    output corner_valid, is_corner, corner_score, corner_x, corner_y
  );

endinterface

// File: rtl/fast_arc_detect.sv
// Combinational wrap-around arc detector.
//   mask : per-pixel class bits in ring order (bit 15 neighbours bit 0)
//   arc  : 1 when some run of ARC_LEN consecutive bits (mod 16) are all set
module fast_arc_detect
  import fast_pkg::*;
#(
  parameter int unsigned ARC_LEN = 9
) (
  input  circle_mask_t mask,
  output logic         arc
);

  logic [ARC_LEN-1:0]  sel [CIRCLE_N];
  logic [CIRCLE_N-1:0] run;

  for (genvar s = 0; s < CIRCLE_N; s++) begin : g_start
    for (genvar k = 0; k < ARC_LEN; k++) begin : g_len
      assign sel[s][k] = mask[(s + k) % CIRCLE_N];
    end
    assign run[s] = &sel[s];
  end

  assign arc = |run;

endmodule

// File: rtl/fast_segment_test.sv
// FAST-16 segment test: classify, arc detect, score. 3-stage valid-only pipeline,
// no backpressure, one result per input window, results in input order.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fast_segment_test_if.slave (window in, corner result out)
// Optional feature: define FAST_SCORE_EN to build the diff registers and score
// adder; otherwise corner_score is tied to 0 and latency is unchanged.
module fast_segment_test
  import fast_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ARC_LEN    = 9,
  parameter int unsigned COORD_W    = 11
) (
  input logic               clk,
  input logic               rst,
  fast_segment_test_if.slave bus
);

  localparam int unsigned EXT_W = DATA_WIDTH + 1;

  // ---------------- Stage 1: classify + coordinates ----------------
  logic [EXT_W-1:0]   c_ext, t_ext, c_plus_t;
  circle_mask_t       bright_d, dark_d;
  circle_mask_t       bright1_q, dark1_q;
  logic               v1_q;
  logic [COORD_W-1:0] x_d, y_d, x_q, y_q;
  logic               eol_pend_q;

  always_comb begin
    c_ext    = {1'b0, bus.center_pixel};
    t_ext    = {1'b0, bus.threshold};
    c_plus_t = c_ext + t_ext;
    bright_d = '0;
    dark_d   = '0;
    for (int i = 0; i < CIRCLE_N; i++) begin
      bright_d[i] = {1'b0, bus.circle_pixel[i]} > c_plus_t;
      dark_d[i]   = ({1'b0, bus.circle_pixel[i]} + t_ext) < c_ext;
    end
  end

  always_comb begin
    x_d = x_q + COORD_W'(1);
    y_d = y_q;
    if (bus.window_sof) begin
      x_d = '0;
      y_d = '0;
    end else if (eol_pend_q) begin
      x_d = '0;
      y_d = y_q + COORD_W'(1);
    end
  end

  // x_q/y_q double as the running counters and the stage-1 coordinate tag:
  // stage 2 copies them on the same edge that a newer window may overwrite them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q       <= 1'b0;
      bright1_q  <= '0;
      dark1_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      eol_pend_q <= 1'b0;
    end else begin
      v1_q <= bus.circle_valid;
      if (bus.circle_valid) begin
        bright1_q  <= bright_d;
        dark1_q    <= dark_d;
        x_q        <= x_d;
        y_q        <= y_d;
        eol_pend_q <= bus.window_eol;
      end
    end
  end

  // ---------------- Stage 2: arc detect ----------------
  logic               arc_b, arc_d;
  logic               v2_q, corner2_q;
  logic [COORD_W-1:0] x2_q, y2_q;

  fast_arc_detect #(.ARC_LEN(ARC_LEN)) u_arc_bright (.mask(bright1_q), .arc(arc_b));
  fast_arc_detect #(.ARC_LEN(ARC_LEN)) u_arc_dark   (.mask(dark1_q),   .arc(arc_d));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q      <= 1'b0;
      corner2_q <= 1'b0;
      x2_q      <= '0;
      y2_q      <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        corner2_q <= arc_b | arc_d;
        x2_q      <= x_q;
        y2_q      <= y_q;
      end
    end
  end

  // ---------------- Stage 3: output registers ----------------
  logic               corner_valid_q, is_corner_q;
  logic [COORD_W-1:0] corner_x_q, corner_y_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corner_valid_q <= 1'b0;
      is_corner_q    <= 1'b0;
      corner_x_q     <= '0;
      corner_y_q     <= '0;
    end else begin
      corner_valid_q <= v2_q;
      if (v2_q) begin
        is_corner_q <= corner2_q;
        corner_x_q  <= x2_q;
        corner_y_q  <= y2_q;
      end
    end
  end

  assign bus.corner_valid = corner_valid_q;
  assign bus.is_corner    = is_corner_q;
  assign bus.corner_x     = corner_x_q;
  assign bus.corner_y     = corner_y_q;

`ifdef FAST_SCORE_EN
  localparam int unsigned SCORE_W = score_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] diff_d  [CIRCLE_N];
  logic [DATA_WIDTH-1:0] diff1_q [CIRCLE_N];
  logic [DATA_WIDTH-1:0] diff2_q [CIRCLE_N];
  circle_mask_t          mask2_q;
  logic [SCORE_W-1:0]    score_sum, score_q;

  // |p - c| - t; only meaningful (and non-negative) for classified pixels.
  always_comb begin
    for (int i = 0; i < CIRCLE_N; i++) begin
      diff_d[i] = (bus.circle_pixel[i] > bus.center_pixel) ?
                  (bus.circle_pixel[i] - bus.center_pixel - bus.threshold) :
                  (bus.center_pixel - bus.circle_pixel[i] - bus.threshold);
    end
  end

  // Whole winning-class mask is scored, not only the detected arc.
  always_comb begin
    score_sum = '0;
    for (int i = 0; i < CIRCLE_N; i++) begin
      if (mask2_q[i]) score_sum = score_sum + SCORE_W'(diff2_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask2_q <= '0;
      score_q <= '0;
      for (int i = 0; i < CIRCLE_N; i++) begin
        diff1_q[i] <= '0;
        diff2_q[i] <= '0;
      end
    end else begin
      if (bus.circle_valid) begin
        for (int i = 0; i < CIRCLE_N; i++) diff1_q[i] <= diff_d[i];
      end
      if (v1_q) begin
        mask2_q <= arc_b ? bright1_q : dark1_q;  // bright wins a tie
        for (int i = 0; i < CIRCLE_N; i++) diff2_q[i] <= diff1_q[i];
      end
      if (v2_q) begin
        score_q <= corner2_q ? score_sum : '0;
      end
    end
  end

  assign bus.corner_score = score_q;
`else
  assign bus.corner_score = '0;
`endif

endmodule

// File: tb/tb_fast_segment_test.sv
// Directed bench for fast_segment_test: single-window classification cases,
// coordinate tagging over a 3x4 frame, and mid-flight reset.
module tb_fast_segment_test;
  import fast_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 11;

`ifdef FAST_SCORE_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  fast_segment_test_if #(.DATA_WIDTH(DW), .COORD_W(CW)) bus ();

  fast_segment_test #(.DATA_WIDTH(DW), .ARC_LEN(9), .COORD_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] pix [16];

  function automatic int exp_score(input int s);
    return SCORE_ON ? s : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 16; i++) pix[i] = 8'(v);
  endtask

  task automatic set_range(input int lo, input int n, input int v);
    for (int k = 0; k < n; k++) pix[(lo + k) % 16] = 8'(v);
  endtask

  task automatic drive(input int c, input int t, input bit sof, input bit eol);
    bus.circle_valid = 1'b1;
    bus.center_pixel = 8'(c);
    bus.threshold    = 8'(t);
    bus.window_sof   = sof;
    bus.window_eol   = eol;
    for (int i = 0; i < 16; i++) bus.circle_pixel[i] = pix[i];
  endtask

  task automatic idle();
    bus.circle_valid = 1'b0;
    bus.window_sof   = 1'b0;
    bus.window_eol   = 1'b0;
  endtask

  // Called #1 after an edge; returns #1 after the edge following the result.
  task automatic run_one(input string tag, input int c, input int t, input bit sof,
                         input bit eol, input int e_corner, input int e_score,
                         input int e_x, input int e_y);
    drive(c, t, sof, eol);
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    check({tag, "_early"}, 32'(bus.corner_valid), 0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(bus.corner_valid), 1);
    check({tag, "_corner"}, 32'(bus.is_corner), 32'(e_corner));
    check({tag, "_score"}, 32'(bus.corner_score), 32'(e_score));
    check({tag, "_x"}, 32'(bus.corner_x), 32'(e_x));
    check({tag, "_y"}, 32'(bus.corner_y), 32'(e_y));
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(bus.corner_valid), 0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    set_all(0);
    bus.center_pixel = '0;
    bus.threshold    = '0;
    for (int i = 0; i < 16; i++) bus.circle_pixel[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.corner_valid), 0);
    check("rst_corner", 32'(bus.is_corner), 0);
    check("rst_score", 32'(bus.corner_score), 0);
    check("rst_x", 32'(bus.corner_x), 0);
    check("rst_y", 32'(bus.corner_y), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Bright arc of 9: diff 30-20=10 per pixel.
    set_all(100); set_range(0, 9, 130);
    run_one("bright9", 100, 20, 1'b1, 1'b0, 1, exp_score(90), 0, 0);

    // Dark arc of 9 wrapping 12..15,0..4: diff 40-20=20 per pixel.
    set_all(100); set_range(12, 9, 60);
    run_one("dark_wrap", 100, 20, 1'b1, 1'b0, 1, exp_score(180), 0, 0);

    // Arc of only 8; sof+eol together tags (0,0).
    set_all(100); set_range(0, 8, 130);
    run_one("arc8", 100, 20, 1'b1, 1'b1, 0, 0, 0, 0);

    // p == c + t is not bright; follows an sof+eol window so tagged (0,1).
    set_all(100); set_range(0, 9, 120);
    run_one("eq_thr", 100, 20, 1'b0, 1'b0, 0, 0, 0, 1);

    // Edge values: 16 * 240.
    set_all(0);
    run_one("edge_dark", 250, 10, 1'b1, 1'b0, 1, exp_score(3840), 0, 0);
    set_all(255);
    run_one("edge_bright", 5, 10, 1'b1, 1'b0, 1, exp_score(3840), 0, 0);

    // Frame: 3 lines x 4 windows, back-to-back.
    set_all(100);
    fork
      begin
        for (int j = 0; j < 12; j++) begin
          drive(100, 20, j == 0, (j % 4) == 3);
          @(posedge clk); #1;
        end
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        for (int j = 0; j < 12; j++) begin
          #1;
          check("frame_valid", 32'(bus.corner_valid), 1);
          check("frame_x", 32'(bus.corner_x), 32'(j % 4));
          check("frame_y", 32'(bus.corner_y), 32'(j / 4));
          @(posedge clk);
        end
        #1;
        check("frame_end", 32'(bus.corner_valid), 0);
      end
    join

    // Reset with two windows in flight.
    set_all(100); set_range(0, 9, 130);
    drive(100, 20, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(100, 20, 1'b0, 1'b0);
    @(posedge clk); #1;
    idle();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.corner_valid), 0);
    check("mid_rst_corner", 32'(bus.is_corner), 0);
    check("mid_rst_score", 32'(bus.corner_score), 0);
    check("mid_rst_x", 32'(bus.corner_x), 0);
    check("mid_rst_y", 32'(bus.corner_y), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      check("flushed", 32'(bus.corner_valid), 0);
    end
    run_one("post_rst", 100, 20, 1'b1, 1'b0, 1, exp_score(90), 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
